// File: rtl/multi_timer.sv
// multi_timer: multi-channel down-counting timer with one-shot/periodic modes, per-channel pause,
// a registered expiry strobe and a sticky interrupt with acknowledge.
module multi_timer #(
    parameter int WIDTH = 16,
    parameter int CHANNELS = 4,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CW-1:0]       load_chan,
    input  logic [WIDTH-1:0]    load_cycles,
    input  logic                load_periodic,
    input  logic [CHANNELS-1:0] pause,
    input  logic [CHANNELS-1:0] irq_ack,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] expire,
    output logic [CHANNELS-1:0] irq,
    output logic                irq_any
);
    logic [WIDTH-1:0]    counter [CHANNELS];
    logic [WIDTH-1:0]    reload [CHANNELS];
    logic [CHANNELS-1:0] periodic;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] fire;

    // A load to a channel overrides its expiry in the same cycle.
    always_comb begin
        hit = '0;
        fire = '0;
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i] = load && (load_chan == CW'(i));
            fire[i] = !hit[i] && !pause[i] && (counter[i] == WIDTH'(1));
            busy[i] = counter[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                counter[i] <= '0;
                reload[i] <= '0;
                periodic[i] <= 1'b0;
            end else if (hit[i]) begin
                counter[i] <= load_cycles;
                reload[i] <= load_cycles;
                periodic[i] <= load_periodic && (load_cycles != '0);
            end else if (fire[i]) begin
                counter[i] <= periodic[i] ? reload[i] : '0;
            end else if (!pause[i] && busy[i]) begin
                counter[i] <= counter[i] - 1'b1;
            end
        end
    end

    // Set wins over acknowledge, so an expiry is never lost.
    always_ff @(posedge clk) begin
        expire <= reset ? '0 : fire;
        irq <= reset ? '0 : ((irq & ~irq_ack) | fire);
    end

    assign irq_any = |irq;
endmodule
